// File: rtl/f9pcap_temac_rx_decap.sv
// rtl/f9pcap_temac_rx_decap.sv - strips the 58-byte Eth/IPv4/UDP/f9pcap header from MAC rx bytes, emits metadata + payload
// Optional payload length check: define F9PCAP_RX_LEN_CHECK_EN.
module f9pcap_temac_rx_decap #(
  parameter int MCG_FILTER_DEFAULT = 1,
  parameter int PLEN_WIDTH         = 16,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  is_f9pcap_en,
  input  logic [31:0]           f9pcap_mcgroup_addr,
  input  logic [15:0]           f9pcap_mcgroup_port,
  input  logic                  rx_valid_in,
  input  logic [7:0]            rx_data_in,
  input  logic                  rx_last_in,
  input  logic                  rx_err_in,
  output logic                  meta_valid_out,
  output logic [63:0]           meta_tts_out,
  output logic [7:0]            meta_sfp_id_out,
  output logic [7:0]            meta_flags_out,
  output logic [PLEN_WIDTH-1:0] meta_plen_out,
  output logic [31:0]           meta_seq_out,
  output logic                  pl_valid_out,
  output logic [7:0]            pl_data_out,
  output logic                  pl_last_out,
  output logic                  pl_err_out,
  output logic [CNT_WIDTH-1:0]  frame_ok_cnt_out,
  output logic [CNT_WIDTH-1:0]  frame_drop_cnt_out,
  output logic [CNT_WIDTH-1:0]  frame_runt_cnt_out
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  localparam bit                  FILTER_EN = (MCG_FILTER_DEFAULT != 0);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = 1;
  localparam logic [PLEN_WIDTH-1:0] PL_ONE  = 1;
  localparam logic [5:0]          HDR_LAST  = 6'd57;

  state_t                r_state;
  logic [5:0]            r_hdr_cnt;
  logic                  r_drop;
  logic [63:0]           r_tts;
  logic [7:0]            r_sfp_id;
  logic [7:0]            r_flags;
  logic [15:0]           r_plen;
  logic [23:0]           r_seq;
  logic [PLEN_WIDTH-1:0] r_pl_cnt;

  logic                  w_mismatch;
  logic [PLEN_WIDTH-1:0] w_pl_cnt_nx;
  logic                  w_len_bad;
  logic                  w_pl_err;

  always_comb begin
    w_mismatch = 1'b0;
    case (r_hdr_cnt)
      6'd12:   w_mismatch = (rx_data_in != 8'h08);
      6'd13:   w_mismatch = (rx_data_in != 8'h00);
      6'd14:   w_mismatch = (rx_data_in != 8'h45);
      6'd23:   w_mismatch = (rx_data_in != 8'h11);
      6'd30:   w_mismatch = FILTER_EN && (rx_data_in != f9pcap_mcgroup_addr[31:24]);
      6'd31:   w_mismatch = FILTER_EN && (rx_data_in != f9pcap_mcgroup_addr[23:16]);
      6'd32:   w_mismatch = FILTER_EN && (rx_data_in != f9pcap_mcgroup_addr[15:8]);
      6'd33:   w_mismatch = FILTER_EN && (rx_data_in != f9pcap_mcgroup_addr[7:0]);
      6'd36:   w_mismatch = FILTER_EN && (rx_data_in != f9pcap_mcgroup_port[15:8]);
      6'd37:   w_mismatch = FILTER_EN && (rx_data_in != f9pcap_mcgroup_port[7:0]);
      default: w_mismatch = 1'b0;
    endcase
  end

  // Count including the current byte, saturating so a huge frame never wraps back to a "matching" length
  assign w_pl_cnt_nx = (r_pl_cnt == {PLEN_WIDTH{1'b1}}) ? r_pl_cnt : r_pl_cnt + PL_ONE;

`ifdef F9PCAP_RX_LEN_CHECK_EN
  assign w_len_bad = (w_pl_cnt_nx != meta_plen_out);
`else
  assign w_len_bad = 1'b0;
`endif

  assign w_pl_err = rx_err_in | w_len_bad;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state            <= S_IDLE;
      r_hdr_cnt          <= '0;
      r_drop             <= 1'b0;
      r_tts              <= '0;
      r_sfp_id           <= '0;
      r_flags            <= '0;
      r_plen             <= '0;
      r_seq              <= '0;
      r_pl_cnt           <= '0;
      meta_valid_out     <= 1'b0;
      meta_tts_out       <= '0;
      meta_sfp_id_out    <= '0;
      meta_flags_out     <= '0;
      meta_plen_out      <= '0;
      meta_seq_out       <= '0;
      pl_valid_out       <= 1'b0;
      pl_data_out        <= '0;
      pl_last_out        <= 1'b0;
      pl_err_out         <= 1'b0;
      frame_ok_cnt_out   <= '0;
      frame_drop_cnt_out <= '0;
      frame_runt_cnt_out <= '0;
    end else begin
      meta_valid_out <= 1'b0;
      pl_valid_out   <= 1'b0;
      pl_last_out    <= 1'b0;
      pl_err_out     <= 1'b0;
      if (rx_valid_in) begin
        case (r_state)
          S_IDLE: begin
            if (rx_last_in) begin
              frame_runt_cnt_out <= frame_runt_cnt_out + CNT_ONE;
            end else begin
              r_state   <= S_HDR;
              r_hdr_cnt <= 6'd1;
              r_drop    <= 1'b0;
            end
          end
          S_HDR: begin
            r_hdr_cnt <= r_hdr_cnt + 6'd1;
            case (r_hdr_cnt)
              6'd42, 6'd43, 6'd44, 6'd45,
              6'd46, 6'd47, 6'd48, 6'd49: r_tts <= {r_tts[55:0], rx_data_in};
              6'd50:                      r_sfp_id <= rx_data_in;
              6'd51:                      r_flags <= rx_data_in;
              6'd52, 6'd53:               r_plen <= {r_plen[7:0], rx_data_in};
              6'd54, 6'd55, 6'd56:        r_seq <= {r_seq[15:0], rx_data_in};
              default: ;
            endcase
            if (rx_last_in) begin
              frame_runt_cnt_out <= frame_runt_cnt_out + CNT_ONE;
              r_state            <= S_IDLE;
            end else if (r_hdr_cnt == HDR_LAST) begin
              if (!r_drop && !w_mismatch && is_f9pcap_en) begin
                meta_valid_out  <= 1'b1;
                meta_tts_out    <= r_tts;
                meta_sfp_id_out <= r_sfp_id;
                meta_flags_out  <= r_flags;
                meta_plen_out   <= PLEN_WIDTH'(r_plen);
                meta_seq_out    <= {r_seq, rx_data_in};
                r_pl_cnt        <= '0;
                r_state         <= S_PAYLOAD;
              end else begin
                r_state <= S_DROP;
              end
            end else if (w_mismatch) begin
              r_drop <= 1'b1;
            end
          end
          S_PAYLOAD: begin
            pl_valid_out <= 1'b1;
            pl_data_out  <= rx_data_in;
            pl_last_out  <= rx_last_in;
            pl_err_out   <= rx_last_in & w_pl_err;
            r_pl_cnt     <= w_pl_cnt_nx;
            if (rx_last_in) begin
              r_state <= S_IDLE;
              if (w_len_bad) frame_drop_cnt_out <= frame_drop_cnt_out + CNT_ONE;
              else           frame_ok_cnt_out   <= frame_ok_cnt_out + CNT_ONE;
            end
          end
          S_DROP: begin
            if (rx_last_in) begin
              r_state            <= S_IDLE;
              frame_drop_cnt_out <= frame_drop_cnt_out + CNT_ONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/f9pcap_temac_rx_decap.md
# f9pcap_temac_rx_decap

Receive-side decapsulator for f9pcap traffic arriving from a tri-mode Ethernet MAC receive port: consumes the 8-bit MAC receive byte stream, validates and strips the 58-byte Ethernet/IPv4/UDP plus f9pcap header, and emits the captured SFP payload bytes with the decoded f9pcap metadata. It is the inverse of the SFP-to-TEMAC encapsulation path and sits between the MAC receive interface and replay/analysis logic.

## Interface
- `MCG_FILTER_DEFAULT`, 1: 1 = filter on destination IP/port; 0 = accept any f9pcap UDP frame.
- `PLEN_WIDTH`, 16: width of the payload length field and the payload byte counter.
- `CNT_WIDTH`, 32: width of the statistics counters.

Ports (all single-clock):
- `clk_in`  in  1  the MAC receive clock; the only clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `is_f9pcap_en`  in  1  0 = drop every frame.
- `f9pcap_mcgroup_addr`  in  32  expected destination IPv4 address.
- `f9pcap_mcgroup_port`  in  16  expected destination UDP port.
- `rx_valid_in`  in  1  MAC byte valid; no backpressure exists.
- `rx_data_in`  in  8  MAC byte.
- `rx_last_in`  in  1  last byte of the frame.
- `rx_err_in`  in  1  MAC frame error; sampled with `rx_last_in`.
- `meta_valid_out`  out  1  one-cycle pulse: header accepted.
- `meta_tts_out`  out  64  f9pcap capture timestamp.
- `meta_sfp_id_out`  out  8  source SFP index.
- `meta_flags_out`  out  8  f9pcap flags byte.
- `meta_plen_out`  out  PLEN_WIDTH  declared payload length.
- `meta_seq_out`  out  32  f9pcap sequence number.
- `pl_valid_out`, `pl_data_out[7:0]`, `pl_last_out`, `pl_err_out`  out  payload byte stream.
- `frame_ok_cnt_out`, `frame_drop_cnt_out`, `frame_runt_cnt_out`  out  CNT_WIDTH  wrapping counters.

## Operation
- Header layout, byte offsets from frame start, big-endian: 12–13 ethertype 0x0800; 14 = 0x45; 23 = 0x11 (UDP); 30–33 destination IP; 36–37 destination port; 42–49 tts; 50 sfp_id; 51 flags; 52–53 payload length; 54–57 seq. Payload starts at byte 58. All other header bytes are ignored.
- States:
  - IDLE: the first valid byte loads hdr_cnt = 1 and enters HDR.
  - HDR: bytes are checked and captured at their offsets; any mismatch latches a drop flag.
  - At byte 57: if the drop flag is clear and `is_f9pcap_en` = 1, pulse `meta_valid_out` and enter PAYLOAD; otherwise enter DROP.
  - PAYLOAD: each byte is forwarded and counted. `rx_last_in` returns to IDLE.
  - DROP: bytes are discarded until `rx_last_in`, then the state returns to IDLE.
- Destination IP/port checks apply only when `MCG_FILTER_DEFAULT` = 1. Ethertype, IHL and protocol are always checked.
- `rx_last_in` at any header byte (offset ≤ 57) is a runt: `frame_runt_cnt_out` +1, return to IDLE, no meta pulse, no payload output.
- Frame accounting at frame end:
  - A frame that completes in PAYLOAD increments `frame_ok_cnt_out`.
  - A frame that completes in DROP increments `frame_drop_cnt_out`.
  - Each frame increments exactly one counter.
- `pl_err_out` is valid only with `pl_last_out`. It is `rx_err_in`, OR'd with the length check when that check is compiled in.
- `rx_valid_in` low mid-frame holds all state and counters.
- Metadata outputs hold their values until the next `meta_valid_out`.

## Timing
- Reset values:
  - `meta_*` outputs, `pl_*` outputs and all counters: 0.
  - State: IDLE.
  - The MAC receive path is reset together with this block; no mid-frame resynchronisation is performed.
- All outputs are registered.
- `meta_valid_out` asserts the cycle after header byte 57 is accepted. All `meta_*` fields are stable in that cycle.
- Payload latency is 1 cycle: the input byte at cycle n appears on `pl_*` at n+1. `pl_last_out` coincides with the delayed `rx_last_in`.
- The first payload byte appears no earlier than the cycle after `meta_valid_out`.
- Counters update the cycle after the byte carrying `rx_last_in`.
- Back-to-back frames (new frame byte in the cycle after `rx_last_in`) are accepted with zero gap.
- The payload byte counter saturates at 2^PLEN_WIDTH−1.

## Configuration
- `F9PCAP_RX_LEN_CHECK_EN` defined:
  - At payload end, the byte count is compared with `meta_plen_out`.
  - On mismatch, `pl_err_out` = 1 on the last byte and `frame_drop_cnt_out` increments instead of `frame_ok_cnt_out`.
  - The payload already forwarded is not retracted.
- Not defined: no comparison is made, `pl_err_out` = `rx_err_in`, and the length field is informational only.

## Test plan
- Valid frame, dst 01.02.03.04:0506, tts 0x1122334455667788, sfp_id 1, plen 64, payload 0x40..0x7f:
  - one `meta_valid_out` with those field values;
  - 64 `pl_*` bytes 40..7f, `pl_last_out` on 7f, `pl_err_out` = 0;
  - ok count = 1.
- Same frame with dst port 0x0507 and `MCG_FILTER_DEFAULT` = 1: no meta pulse, no payload output, drop count = 1. With `MCG_FILTER_DEFAULT` = 0: accepted.
- 40-byte frame ending with `rx_last_in`: runt count = 1, no output; the next valid frame is decoded normally.
- Plen field 64 with 63 actual payload bytes:
  - with `F9PCAP_RX_LEN_CHECK_EN`: `pl_err_out` = 1 on byte 63, drop count = 1;
  - without it: `pl_err_out` = 0, ok count = 1.
- Two frames back-to-back with `rx_valid_in` toggling every other cycle, and `rx_err_in` = 1 on the second frame's last byte:
  - both metas are correct;
  - the second frame's `pl_err_out` = 1;
  - ok count = 2, because a MAC error alone does not change the counter classification.
- `rst_in` asserted at payload byte 20: all outputs are 0 immediately; after release, the next full frame decodes correctly.
